// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instruction/data bus arbiter with BRAM/UART/CLINT decode and timeout
module mem_arbiter #(
    parameter int          bram_depth      = 10,
    parameter logic [31:0] uart_base_addr  = 32'h0010_0000,
    parameter logic [31:0] uart_top_addr   = 32'h0010_0004,
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
    parameter int          timeout         = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_error,

    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,

    output logic        bram_valid,
    input  logic        bram_ready,
    input  logic [31:0] bram_rdata,

    output logic        uart_valid,
    input  logic        uart_ready,
    input  logic [31:0] uart_rdata,

    output logic        clint_valid,
    input  logic        clint_ready,
    input  logic [31:0] clint_rdata
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_issue = 2'd1;
    localparam logic [1:0] st_wait  = 2'd2;
    localparam logic [1:0] st_err   = 2'd3;

    localparam logic [32:0] bram_limit  = 33'd1 << (bram_depth + 2);
    localparam logic [15:0] timeout_cnt = 16'(timeout);

    logic [1:0]  state;
    logic        owner_d;       // 1 = data port owns the current transaction
    logic        last_grant_d;  // winner of the most recent conflict
    logic [2:0]  sel;           // one-hot {clint, uart, bram}
    logic [15:0] wait_cnt;

    logic        grant_any;
    logic        grant_d;
    logic [31:0] grant_addr;
    logic        hit_bram;
    logic        hit_uart;
    logic        hit_clint;
    logic [2:0]  grant_sel;

    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;
    logic        resp_done;
    logic        resp_ok;
    logic [31:0] resp_rdata;
    logic        resp_error;

    // On contention the port that lost the previous conflict wins.
    always_comb begin
        grant_any  = imem_valid | dmem_valid;
        grant_d    = (imem_valid && dmem_valid) ? ~last_grant_d : dmem_valid;
        grant_addr = grant_d ? dmem_addr : imem_addr;
        hit_bram   = ({1'b0, grant_addr} < bram_limit);
        hit_uart   = (grant_addr >= uart_base_addr) && (grant_addr < uart_top_addr);
        hit_clint  = (grant_addr >= clint_base_addr) && (grant_addr < clint_top_addr);
        grant_sel  = 3'b000;
        if (hit_bram) begin
            grant_sel = 3'b001;
        end else if (hit_uart) begin
            grant_sel = 3'b010;
        end else if (hit_clint) begin
            grant_sel = 3'b100;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= st_idle;
            owner_d      <= 1'b0;
            last_grant_d <= 1'b0;
            sel          <= 3'b000;
            wait_cnt     <= 16'd0;
            bus_addr     <= 32'd0;
            bus_wdata    <= 32'd0;
            bus_wstrb    <= 4'd0;
        end else begin
            case (state)
                st_idle: begin
                    if (grant_any) begin
                        owner_d   <= grant_d;
                        bus_addr  <= grant_addr;
                        bus_wdata <= grant_d ? dmem_wdata : 32'd0;
                        bus_wstrb <= grant_d ? dmem_wstrb : 4'd0;
                        sel       <= grant_sel;
                        if (imem_valid && dmem_valid) begin
                            last_grant_d <= grant_d;
                        end
                        state <= (grant_sel != 3'b000) ? st_issue : st_err;
                    end
                end
                st_issue: begin
                    wait_cnt <= 16'd0;
                    state    <= st_wait;
                end
                st_wait: begin
                    if (sel_ready || timeout_hit) begin
                        state <= st_idle;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    always_comb begin
        sel_ready = |(sel & {clint_ready, uart_ready, bram_ready});
        sel_rdata = 32'd0;
        case (sel)
            3'b001:  sel_rdata = bram_rdata;
            3'b010:  sel_rdata = uart_rdata;
            3'b100:  sel_rdata = clint_rdata;
            default: sel_rdata = 32'd0;
        endcase
    end

    // A slave answering in the same cycle the counter expires still wins.
    always_comb begin
        timeout_hit = (wait_cnt == timeout_cnt);
        resp_ok     = (state == st_wait) && sel_ready;
        resp_done   = (state == st_err) || ((state == st_wait) && (sel_ready || timeout_hit));
        resp_rdata  = resp_ok ? sel_rdata : 32'd0;
        resp_error  = resp_done && !resp_ok;
    end

    always_comb begin
        imem_ready  = resp_done && !owner_d;
        imem_rdata  = (resp_done && !owner_d) ? resp_rdata : 32'd0;
        imem_error  = resp_error && !owner_d;
        dmem_ready  = resp_done && owner_d;
        dmem_rdata  = (resp_done && owner_d) ? resp_rdata : 32'd0;
        dmem_error  = resp_error && owner_d;
        bram_valid  = (state == st_issue) && sel[0];
        uart_valid  = (state == st_issue) && sel[1];
        clint_valid = (state == st_issue) && sel[2];
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int TO    = 4;
    localparam int NEVER = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = 32'd0;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = 32'd0;
    logic [31:0] dmem_wdata = 32'd0;
    logic [3:0]  dmem_wstrb = 4'd0;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_error;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bram_valid, uart_valid, clint_valid;
    logic        bram_ready = 1'b0, uart_ready = 1'b0, clint_ready = 1'b0;
    logic [31:0] bram_rdata = 32'd0, uart_rdata = 32'd0, clint_rdata = 32'd0;

    int   vec  = 0;
    int   errs = 0;
    logic model_last_d = 1'b0;

    mem_arbiter #(.timeout(TO)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_error(dmem_error),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bram_valid(bram_valid), .bram_ready(bram_ready), .bram_rdata(bram_rdata),
        .uart_valid(uart_valid), .uart_ready(uart_ready), .uart_rdata(uart_rdata),
        .clint_valid(clint_valid), .clint_ready(clint_ready), .clint_rdata(clint_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = unmapped, 1 = BRAM, 2 = UART, 3 = CLINT
    function automatic int region(input logic [31:0] a);
        if (a < 32'h0000_1000) return 1;
        if (a >= 32'h0010_0000 && a < 32'h0010_0004) return 2;
        if (a >= 32'h0200_0000 && a < 32'h0200_C000) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [12] = '{32'h0, 32'h10, 32'hFFC, 32'hFFF, 32'h1000, 32'h100000,
                                  32'h100003, 32'h100004, 32'h2000000, 32'h200BFFF,
                                  32'h200C000, 32'h2004000};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom & 32'hFFF;
            default: return tbl[$urandom_range(0, 11)];
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic new_req(input logic d);
        if (d) begin
            dmem_addr  = pick_addr();
            dmem_wdata = $urandom;
            dmem_wstrb = 4'($urandom_range(0, 15));
        end else begin
            imem_addr = pick_addr();
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " imem_ready"}, imem_ready, 0);
        chk({tag, " imem_rdata"}, imem_rdata, 0);
        chk({tag, " imem_error"}, imem_error, 0);
        chk({tag, " dmem_ready"}, dmem_ready, 0);
        chk({tag, " dmem_rdata"}, dmem_rdata, 0);
        chk({tag, " dmem_error"}, dmem_error, 0);
        chk({tag, " bus_addr"}, bus_addr, 0);
        chk({tag, " bus_wdata"}, bus_wdata, 0);
        chk({tag, " bus_wstrb"}, bus_wstrb, 0);
        chk({tag, " slave_valids"}, {bram_valid, uart_valid, clint_valid}, 0);
    endtask

    // Serves one grant starting in the current (IDLE) cycle; slave answers lat cycles after WAIT entry.
    task automatic txn(input int lat, input logic [31:0] srdata, input logic keep);
        logic        win_d;
        logic [31:0] a;
        int          r;
        int          done;
        logic        exp_err;
        logic [31:0] exp_rd;
        if (imem_valid && dmem_valid) begin
            win_d        = !model_last_d;
            model_last_d = win_d;
        end else begin
            win_d = dmem_valid;
        end
        a = win_d ? dmem_addr : imem_addr;
        r = region(a);
        if (r == 0) begin
            done = 1; exp_err = 1'b1; exp_rd = 32'd0;
        end else if (lat <= TO) begin
            done = 2 + lat; exp_err = 1'b0; exp_rd = srdata;
        end else begin
            done = 2 + TO; exp_err = 1'b1; exp_rd = 32'd0;
        end
        for (int c = 0; c <= done; c++) begin
            bram_ready  = (r == 1) ? (c == 2 + lat) : 1'($urandom_range(0, 1));
            bram_rdata  = (r == 1 && c == 2 + lat) ? srdata : $urandom;
            uart_ready  = (r == 2) ? (c == 2 + lat) : 1'($urandom_range(0, 1));
            uart_rdata  = (r == 2 && c == 2 + lat) ? srdata : $urandom;
            clint_ready = (r == 3) ? (c == 2 + lat) : 1'($urandom_range(0, 1));
            clint_rdata = (r == 3 && c == 2 + lat) ? srdata : $urandom;
            @(negedge clock);
            chk("bram_valid", bram_valid, (c == 1 && r == 1));
            chk("uart_valid", uart_valid, (c == 1 && r == 2));
            chk("clint_valid", clint_valid, (c == 1 && r == 3));
            chk("imem_ready", imem_ready, (c == done && !win_d));
            chk("imem_rdata", imem_rdata, (c == done && !win_d) ? exp_rd : 32'd0);
            chk("imem_error", imem_error, (c == done && !win_d) ? exp_err : 1'b0);
            chk("dmem_ready", dmem_ready, (c == done && win_d));
            chk("dmem_rdata", dmem_rdata, (c == done && win_d) ? exp_rd : 32'd0);
            chk("dmem_error", dmem_error, (c == done && win_d) ? exp_err : 1'b0);
            if (c == 1) begin
                chk("bus_addr", bus_addr, a);
                chk("bus_wstrb", bus_wstrb, win_d ? dmem_wstrb : 4'd0);
                if (win_d) chk("bus_wdata", bus_wdata, dmem_wdata);
            end
            next_cycle();
        end
        if (!keep) begin
            if (win_d) dmem_valid = 1'b0;
            else       imem_valid = 1'b0;
        end else begin
            new_req(win_d);
        end
        bram_ready = 1'b0; uart_ready = 1'b0; clint_ready = 1'b0;
    endtask

    task automatic idle_check(input int n, input logic late_clint);
        for (int c = 0; c < n; c++) begin
            clint_ready = late_clint ? 1'b1 : 1'($urandom_range(0, 1));
            clint_rdata = $urandom;
            bram_ready  = 1'($urandom_range(0, 1));
            uart_ready  = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("idle imem_ready", imem_ready, 0);
            chk("idle dmem_ready", dmem_ready, 0);
            chk("idle dmem_rdata", dmem_rdata, 0);
            chk("idle slave_valids", {bram_valid, uart_valid, clint_valid}, 0);
            next_cycle();
        end
        bram_ready = 1'b0; uart_ready = 1'b0; clint_ready = 1'b0;
    endtask

    task automatic dreq(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        dmem_valid = 1'b1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws;
    endtask

    initial begin
        logic [31:0] bnd [6];
        bnd = '{32'h1000, 32'h100004, 32'h200C000, 32'hFFF, 32'h100003, 32'h200BFFF};

        // Reset state
        next_cycle();
        @(negedge clock);
        check_quiet("reset");
        next_cycle();
        reset = 1'b1;
        model_last_d = 1'b0;
        next_cycle();

        // BRAM read, zero-wait slave
        dreq(32'h10, 32'h0, 4'h0);
        txn(0, 32'hDEADBEEF, 1'b0);

        // Contention: back-to-back requests from both ports
        imem_valid = 1'b1; imem_addr = 32'h4;
        dreq(32'h8, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 4; i++) txn(0, $urandom, 1'b1);
        imem_valid = 1'b0; dmem_valid = 1'b0;
        next_cycle();

        // UART write with three wait cycles
        dreq(32'h100000, 32'h41, 4'h1);
        txn(3, 32'h0, 1'b0);

        // Region boundaries
        for (int i = 0; i < 6; i++) begin
            dreq(bnd[i], 32'h0, 4'h0);
            txn(1, 32'hC0DE_0000 + 32'(i), 1'b0);
        end

        // CLINT never answers; a late ready must be ignored
        dreq(32'h2004000, 32'h0, 4'h0);
        txn(NEVER, 32'h0, 1'b0);
        idle_check(2, 1'b1);

        // Reset while waiting on the slave
        dreq(32'h20, 32'h0, 4'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check_quiet("midreset");
        dmem_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check_quiet("inreset");
            next_cycle();
        end
        reset = 1'b1;
        model_last_d = 1'b0;
        next_cycle();
        dreq(32'h40, 32'h0, 4'h0);
        txn(0, 32'hA5A5_5A5A, 1'b0);
        imem_valid = 1'b1; imem_addr = 32'h100;
        dreq(32'h200, 32'h0, 4'h0);
        txn(1, 32'h1111_2222, 1'b0);
        txn(2, 32'h3333_4444, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (!imem_valid && $urandom_range(0, 1) == 1) begin
                imem_valid = 1'b1; new_req(1'b0);
            end
            if (!dmem_valid && $urandom_range(0, 1) == 1) begin
                dmem_valid = 1'b1; new_req(1'b1);
            end
            if (!imem_valid && !dmem_valid) begin
                dmem_valid = 1'b1; new_req(1'b1);
            end
            txn($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
        end
        imem_valid = 1'b0; dmem_valid = 1'b0;
        next_cycle();
        idle_check(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
